// File: rtl/caravan_por_pkg.sv
// Shared constants and the status-to-check-code decode for the caravan dual POR monitor.
package caravan_por_pkg;

    localparam logic [3:0] CHK_NONE  = 4'h0;
    localparam logic [3:0] CHK_POR1  = 4'h9;
    localparam logic [3:0] CHK_BOTH  = 4'h5;
    localparam logic [3:0] CHK_FAULT = 4'h6;

    localparam int POR1_BIT = 0;
    localparam int POR2_BIT = 1;

    // Auxiliary good without core good is reported as a distinct fault code.
    function automatic logic [3:0] chk_decode(input logic [1:0] good);
        logic [3:0] code;
        case (good)
            2'b01:   code = CHK_POR1;
            2'b11:   code = CHK_BOTH;
            2'b10:   code = CHK_FAULT;
            default: code = CHK_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/caravan_por_monitor_if.sv
// Sense inputs, pad enable and status/check outputs of the POR monitor.
interface caravan_por_monitor_if;

    logic       vdd1_sense;
    logic       vdd2_sense;
    logic       cfg_en;
    logic [1:0] status;
    logic [3:0] checkbits;
    logic [1:0] por_good;

    modport master (
        output vdd1_sense,
        output vdd2_sense,
        output cfg_en,
        input  status,
        input  checkbits,
        input  por_good
    );

    modport slave (
        input  vdd1_sense,
        input  vdd2_sense,
        input  cfg_en,
        output status,
        output checkbits,
        output por_good
    );

endinterface

// File: rtl/caravan_por_monitor_por_filter.sv
// One POR channel: synchronize the sense level, then require DELAY consecutive high samples.
module por_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int DELAY       = 64,
    parameter int CNT_W       = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic sense,
    output logic good
);

    localparam logic [CNT_W-1:0] DLY    = CNT_W'(DELAY);
    localparam logic [CNT_W-1:0] DLY_M1 = CNT_W'(DELAY - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   good_q, good_d;
    logic                   s;

    assign s    = sync_q[SYNC_STAGES-1];
    assign good = good_q;

    // Any low sample restarts the full delay; the count saturates so good never drops while s stays high.
    always_comb begin
        cnt_d  = cnt_q;
        good_d = good_q;
        if (!s) begin
            cnt_d  = '0;
            good_d = 1'b0;
        end else begin
            if (cnt_q != DLY)
                cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == DLY_M1)
                good_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            good_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sense};
            cnt_q  <= cnt_d;
            good_q <= good_d;
        end
    end

endmodule

// File: rtl/caravan_por_monitor.sv
// Dual POR monitor top: two independent filtered channels, check-code decode and pad gating.
module caravan_por_monitor
    import caravan_por_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int POR1_DELAY  = 64,
    parameter int POR2_DELAY  = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    caravan_por_monitor_if.slave bus
);

    logic [1:0] good;

    por_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .DELAY       (POR1_DELAY),
        .CNT_W       (CNT_W)
    ) u_por1 (
        .clock (clock),
        .reset (reset),
        .sense (bus.vdd1_sense),
        .good  (good[POR1_BIT])
    );

    por_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .DELAY       (POR2_DELAY),
        .CNT_W       (CNT_W)
    ) u_por2 (
        .clock (clock),
        .reset (reset),
        .sense (bus.vdd2_sense),
        .good  (good[POR2_BIT])
    );

    // Gating is purely combinational so raising cfg_en exposes the current state immediately.
    assign bus.por_good  = good;
    assign bus.status    = bus.cfg_en ? good : 2'b00;
    assign bus.checkbits = bus.cfg_en ? chk_decode(good) : CHK_NONE;

endmodule

// File: tb/tb_caravan_por_monitor.sv
// Directed bench for caravan_por_monitor with a queue of expected pad/status values.
module tb_caravan_por_monitor;

    logic clock;
    logic reset;

    caravan_por_monitor_if bus ();

    caravan_por_monitor #(
        .SYNC_STAGES (2),
        .POR1_DELAY  (64),
        .POR2_DELAY  (64),
        .CNT_W       (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0] st;
        logic [3:0] ck;
        logic [1:0] pg;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [1:0] st, input logic [3:0] ck,
                            input logic [1:0] pg);
        exp_t e;
        e.st = st;
        e.ck = ck;
        e.pg = pg;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check();
        exp_t  e;
        exp_t  o;
        string tag;
        e   = sb_q.pop_front();
        tag = tag_q.pop_front();
        o.st = bus.status;
        o.ck = bus.checkbits;
        o.pg = bus.por_good;
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed status=%b checkbits=%h por_good=%b expected status=%b checkbits=%h por_good=%b",
                   tag, o.st, o.ck, o.pg, e.st, e.ck, e.pg);
        end
    endtask

    // Queue the expectation now, let n edges elapse, then compare.
    task automatic expect_after(input int n, input string tag, input logic [1:0] st,
                                input logic [3:0] ck, input logic [1:0] pg);
        push_exp(tag, st, ck, pg);
        tick(n);
        pop_check();
    endtask

    initial begin
        reset          = 1'b1;
        bus.vdd1_sense = 1'b1;
        bus.vdd2_sense = 1'b1;
        bus.cfg_en     = 1'b1;
        tick(3);
        expect_after(0, "reset_held", 2'b00, 4'h0, 2'b00);

        // Scenario 1: POR1 alone; first sample edge is the next posedge after release
        bus.vdd2_sense = 1'b0;
        reset          = 1'b0;
        expect_after(65, "por1_edge65", 2'b00, 4'h0, 2'b00);
        expect_after(1,  "por1_edge66", 2'b01, 4'h9, 2'b01);

        // Scenario 2: POR2 on top of POR1
        bus.vdd2_sense = 1'b1;
        expect_after(30, "por2_mid",    2'b01, 4'h9, 2'b01);
        expect_after(35, "por2_edge65", 2'b01, 4'h9, 2'b01);
        expect_after(1,  "por2_edge66", 2'b11, 4'h5, 2'b11);

        // Scenario 3: one-cycle low after good, then a glitch mid-count
        bus.vdd1_sense = 1'b0;
        tick(1);
        bus.vdd1_sense = 1'b1;
        expect_after(2,  "glitch_clear", 2'b10, 4'h6, 2'b10);
        expect_after(28, "recount_mid",  2'b10, 4'h6, 2'b10);
        bus.vdd1_sense = 1'b0;
        tick(1);
        bus.vdd1_sense = 1'b1;
        expect_after(65, "restart_edge65", 2'b10, 4'h6, 2'b10);
        expect_after(1,  "restart_edge66", 2'b11, 4'h5, 2'b11);

        // Scenario 4: gating
        bus.cfg_en = 1'b0;
        expect_after(0, "gate_off_now", 2'b00, 4'h0, 2'b11);
        expect_after(5, "gate_off_hold", 2'b00, 4'h0, 2'b11);
        bus.cfg_en = 1'b1;
        expect_after(0, "gate_on_now", 2'b11, 4'h5, 2'b11);

        // Scenario 5: hold vdd1 low with POR2 good, counters keep running while gated
        bus.vdd1_sense = 1'b0;
        expect_after(2, "vdd1_low_edge2", 2'b11, 4'h5, 2'b11);
        expect_after(1, "vdd1_low_edge3", 2'b10, 4'h6, 2'b10);
        expect_after(5, "vdd1_low_hold",  2'b10, 4'h6, 2'b10);
        bus.vdd1_sense = 1'b1;
        bus.cfg_en     = 1'b0;
        expect_after(65, "restore_gated", 2'b00, 4'h0, 2'b10);
        expect_after(1,  "restore_good_gated", 2'b00, 4'h0, 2'b11);
        bus.cfg_en = 1'b1;
        expect_after(0,  "restore_exposed", 2'b11, 4'h5, 2'b11);

        // Scenario 6: reset in the middle of a POR2 count
        bus.vdd2_sense = 1'b0;
        expect_after(3, "vdd2_low", 2'b01, 4'h9, 2'b01);
        bus.vdd2_sense = 1'b1;
        tick(30);
        #2;
        reset = 1'b1;
        expect_after(0, "reset_mid_async", 2'b00, 4'h0, 2'b00);
        tick(2);
        reset = 1'b0;
        expect_after(65, "post_reset_edge65", 2'b00, 4'h0, 2'b00);
        expect_after(1,  "post_reset_edge66", 2'b11, 4'h5, 2'b11);

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
